// File: rtl/r_channel_fifo.sv
// rtl/r_channel_fifo.sv - OBI R-channel response buffer with A-channel slot reservation
//
// Buffers read responses {rdata, err, rid} from the cache controller in a
// DEPTH-entry circular FIFO and presents the head entry to the OBI master
// under rvalid/rready handshaking. A reservation counter tracks accepted
// A-channel requests whose responses have not yet been popped, and gates
// internal_gnt so the controller can never return a response without space.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_i            A-channel request presented
//   internal_gnt     grant to A-channel (accept = req_i && internal_gnt)
//   rvalid_in        controller response valid (one pulse per response)
//   rdata_in         controller read data
//   err_in           controller error flag
//   rid_in           controller transaction ID
//   rvalid_o         OBI rvalid (head entry valid)
//   rready_i         OBI rready from master
//   rdata_o          OBI rdata (head entry)
//   err_o            OBI err (head entry)
//   rid_o            OBI rid (head entry)
//   count_o          current FIFO occupancy
//   overflow_o       sticky flag: response arrived while full with no pop

module r_channel_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    output logic                  internal_gnt,
    input  logic                  rvalid_in,
    input  logic [DATA_WIDTH-1:0] rdata_in,
    input  logic                  err_in,
    input  logic [ID_WIDTH-1:0]   rid_in,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  overflow_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + 1 + ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]     wp_q, wp_d;
    logic [PTR_W-1:0]     rp_q, rp_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] res_q, res_d;
    logic                 ovf_q, ovf_d;

    logic full;
    logic push;
    logic pop;
    logic accept;

    assign rvalid_o     = (cnt_q != '0);
    assign internal_gnt = (res_q < DEPTH_C);
    assign count_o      = cnt_q;
    assign overflow_o   = ovf_q;
    assign {rdata_o, err_o, rid_o} = mem_q[rp_q];

    always_comb begin
        full   = (cnt_q == DEPTH_C);
        pop    = rvalid_o && rready_i;
        // A pop in the same cycle frees the head slot, so a full FIFO can still take a response.
        push   = rvalid_in && (!full || pop);
        accept = req_i && internal_gnt;

        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        res_d = res_q + CNT_WIDTH'(accept) - CNT_WIDTH'(pop);
        ovf_d = ovf_q | (rvalid_in && full && !pop);

        // Pointers wrap naturally since DEPTH is a power of two.
        if (push) begin
            wp_d = wp_q + PTR_W'(1);
        end
        if (pop) begin
            rp_d = rp_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
            if (push) begin
                mem_q[wp_q] <= {rdata_in, err_in, rid_in};
            end
        end
    end

endmodule

// File: tb/tb_r_channel_fifo.sv
// tb/tb_r_channel_fifo.sv - directed self-checking bench for r_channel_fifo

module tb_r_channel_fifo;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        internal_gnt;
    logic        rvalid_in;
    logic [63:0] rdata_in;
    logic        err_in;
    logic [3:0]  rid_in;
    logic        rvalid_o;
    logic        rready_i;
    logic [63:0] rdata_o;
    logic        err_o;
    logic [3:0]  rid_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    r_channel_fifo #(
        .DATA_WIDTH(64),
        .ID_WIDTH  (4),
        .DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .internal_gnt(internal_gnt),
        .rvalid_in   (rvalid_in),
        .rdata_in    (rdata_in),
        .err_in      (err_in),
        .rid_in      (rid_in),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .rid_o       (rid_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic reserve(input int n);
        for (int i = 0; i < n; i++) begin
            req_i = 1'b1;
            tick();
        end
        req_i = 1'b0;
    endtask

    task automatic push(input logic [3:0] rid, input logic [63:0] data, input logic err);
        rvalid_in = 1'b1;
        rid_in    = rid;
        rdata_in  = data;
        err_in    = err;
        tick();
        rvalid_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rvalid_o !== 1'b0)     begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid_o); end
        n_checks++; if (count_o !== 3'd0)      begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
        n_checks++; if (internal_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt got %b want 1", internal_gnt); end
        n_checks++; if (overflow_o !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    endtask

    task automatic test_single_read();
        do_reset();
        reserve(1);
        n_checks++; if (internal_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt got %b want 1", internal_gnt); end
        n_checks++; if (rvalid_o !== 1'b0)     begin n_fail++; $display("FAIL single_pre_rvalid got %b want 0", rvalid_o); end
        push(4'd3, 64'hDEAD_BEEF_0000_0001, 1'b0);
        n_checks++; if (rvalid_o !== 1'b1)     begin n_fail++; $display("FAIL single_rvalid got %b want 1", rvalid_o); end
        n_checks++; if (rdata_o !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL single_rdata got %h want deadbeef00000001", rdata_o); end
        n_checks++; if (rid_o !== 4'd3)        begin n_fail++; $display("FAIL single_rid got %0d want 3", rid_o); end
        n_checks++; if (err_o !== 1'b0)        begin n_fail++; $display("FAIL single_err got %b want 0", err_o); end
        n_checks++; if (count_o !== 3'd1)      begin n_fail++; $display("FAIL single_count1 got %0d want 1", count_o); end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        n_checks++; if (count_o !== 3'd0)      begin n_fail++; $display("FAIL single_count0 got %0d want 0", count_o); end
        n_checks++; if (rvalid_o !== 1'b0)     begin n_fail++; $display("FAIL single_post_rvalid got %b want 0", rvalid_o); end
    endtask

    task automatic test_fill();
        do_reset();
        reserve(4);
        n_checks++; if (internal_gnt !== 1'b0) begin n_fail++; $display("FAIL fill_gnt_low got %b want 0", internal_gnt); end
        // A request while grant is low must not be counted.
        reserve(1);
        for (int i = 0; i < 4; i++) begin
            push(4'(i), 64'(100 + i), 1'b0);
        end
        n_checks++; if (count_o !== 3'd4)      begin n_fail++; $display("FAIL fill_count got %0d want 4", count_o); end
        n_checks++; if (rid_o !== 4'd0)        begin n_fail++; $display("FAIL fill_head got %0d want 0", rid_o); end
        tick();
        tick();
        n_checks++; if (rid_o !== 4'd0 || rdata_o !== 64'd100 || rvalid_o !== 1'b1) begin
            n_fail++; $display("FAIL fill_head_stable got rid %0d data %0d v %b want rid 0 data 100 v 1", rid_o, rdata_o, rvalid_o);
        end
        rready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rvalid_o !== 1'b1 || rid_o !== 4'(i) || rdata_o !== 64'(100 + i)) begin
                n_fail++; $display("FAIL fill_drain%0d got v %b rid %0d data %0d want v 1 rid %0d data %0d", i, rvalid_o, rid_o, rdata_o, i, 100 + i);
            end
            tick();
        end
        rready_i = 1'b0;
        n_checks++; if (rvalid_o !== 1'b0)     begin n_fail++; $display("FAIL fill_empty got %b want 0", rvalid_o); end
        n_checks++; if (internal_gnt !== 1'b1) begin n_fail++; $display("FAIL fill_gnt_back got %b want 1", internal_gnt); end
    endtask

    task automatic test_push_pop_full();
        logic [3:0] exp_rid [4];
        exp_rid[0] = 4'd11; exp_rid[1] = 4'd12; exp_rid[2] = 4'd13; exp_rid[3] = 4'd14;
        do_reset();
        reserve(4);
        for (int i = 0; i < 4; i++) begin
            push(4'(10 + i), 64'(10 + i), 1'b0);
        end
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL ppf_full got %0d want 4", count_o); end
        rready_i = 1'b1;
        push(4'd14, 64'd14, 1'b0);
        rready_i = 1'b0;
        n_checks++; if (count_o !== 3'd4)    begin n_fail++; $display("FAIL ppf_count got %0d want 4", count_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ppf_ovf got %b want 0", overflow_o); end
        rready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rvalid_o !== 1'b1 || rid_o !== exp_rid[i]) begin
                n_fail++; $display("FAIL ppf_order%0d got v %b rid %0d want v 1 rid %0d", i, rvalid_o, rid_o, exp_rid[i]);
            end
            tick();
        end
        rready_i = 1'b0;
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ppf_empty got %b want 0", rvalid_o); end
        do_reset();
    endtask

    task automatic test_overflow();
        do_reset();
        reserve(4);
        for (int i = 0; i < 4; i++) begin
            push(4'(i), 64'(i), 1'b0);
        end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b want 0", overflow_o); end
        push(4'd9, 64'd9, 1'b1);
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow_o); end
        n_checks++; if (count_o !== 3'd4)    begin n_fail++; $display("FAIL ovf_count got %0d want 4", count_o); end
        n_checks++; if (rid_o !== 4'd0)      begin n_fail++; $display("FAIL ovf_head got %0d want 0", rid_o); end
        tick();
        tick();
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
        rready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rvalid_o !== 1'b1 || rid_o !== 4'(i)) begin
                n_fail++; $display("FAIL ovf_drain%0d got v %b rid %0d want v 1 rid %0d", i, rvalid_o, rid_o, i);
            end
            tick();
        end
        rready_i = 1'b0;
        n_checks++; if (rvalid_o !== 1'b0)   begin n_fail++; $display("FAIL ovf_dropped got %b want 0", rvalid_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky2 got %b want 1", overflow_o); end
    endtask

    task automatic test_wrap();
        int acc    = 0;
        int pushed = 0;
        int rx     = 0;
        int cycles = 0;
        do_reset();
        while (rx < 10 && cycles < 400) begin
            rready_i = 1'($urandom_range(0, 1));
            if (rvalid_o && rready_i) begin
                n_checks++; if (rdata_o !== 64'(rx) || err_o !== (rx == 7) || rid_o !== 4'(rx)) begin
                    n_fail++; $display("FAIL wrap_item%0d got data %0d err %b rid %0d want data %0d err %b", rx, rdata_o, err_o, rid_o, rx, (rx == 7));
                end
                rx++;
            end
            // Respond only to requests accepted in earlier cycles.
            if (pushed < acc) begin
                rvalid_in = 1'b1;
                rdata_in  = 64'(pushed);
                rid_in    = 4'(pushed);
                err_in    = (pushed == 7);
                pushed++;
            end else begin
                rvalid_in = 1'b0;
            end
            req_i = (acc < 10);
            if (req_i && internal_gnt) acc++;
            tick();
            cycles++;
        end
        req_i     = 1'b0;
        rvalid_in = 1'b0;
        rready_i  = 1'b0;
        n_checks++; if (rx != 10) begin n_fail++; $display("FAIL wrap_timeout got %0d items want 10", rx); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got %b want 0", overflow_o); end
        n_checks++; if (internal_gnt !== 1'b1 || rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL wrap_idle got gnt %b v %b want gnt 1 v 0", internal_gnt, rvalid_o);
        end
    endtask

    task automatic test_reset_midop();
        // Runs after the overflow scenario, so overflow_o is still set on entry.
        reserve(4);
        for (int i = 0; i < 3; i++) begin
            push(4'(i), 64'(i), 1'b0);
        end
        n_checks++; if (count_o !== 3'd3)      begin n_fail++; $display("FAIL mid_count got %0d want 3", count_o); end
        n_checks++; if (internal_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_gnt got %b want 0", internal_gnt); end
        do_reset();
        n_checks++; if (rvalid_o !== 1'b0)     begin n_fail++; $display("FAIL mid_rvalid got %b want 0", rvalid_o); end
        n_checks++; if (count_o !== 3'd0)      begin n_fail++; $display("FAIL mid_count0 got %0d want 0", count_o); end
        n_checks++; if (internal_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt1 got %b want 1", internal_gnt); end
        n_checks++; if (overflow_o !== 1'b0)   begin n_fail++; $display("FAIL mid_ovf got %b want 0", overflow_o); end
        tick();
        n_checks++; if (rvalid_o !== 1'b0)     begin n_fail++; $display("FAIL mid_empty got %b want 0", rvalid_o); end
    endtask

    initial begin
        rst       = 1'b1;
        req_i     = 1'b0;
        rvalid_in = 1'b0;
        rdata_in  = '0;
        err_in    = 1'b0;
        rid_in    = '0;
        rready_i  = 1'b0;
        tick();
        tick();
        test_reset();
        test_single_read();
        test_fill();
        test_push_pop_full();
        test_wrap();
        test_overflow();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
